// File: rtl/i3c_pkg.sv
`default_nettype none
// ============================================================================
// i3c_pkg : shared bus-state types and monitor FSM encodings
// Rev 1.0
// ============================================================================
package i3c_pkg;

  typedef struct packed {
    logic stable_high;
    logic stable_low;
    logic pos_edge;
    logic neg_edge;
  } line_state_t;

  typedef struct packed {
    line_state_t scl;
    line_state_t sda;
    logic        start_det;
    logic        rstart_det;
    logic        stop_det;
  } bus_state_t;

  typedef enum logic [1:0] {
    HdrIdle     = 2'd0,
    HdrArmed    = 2'd1,
    HdrWaitStop = 2'd2
  } hdr_mon_state_e;

  typedef enum logic [1:0] {
    TrstIdle   = 2'd0,
    TrstCount  = 2'd1,
    TrstWaitSr = 2'd2,
    TrstWaitP  = 2'd3
  } trst_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i3c_bus_condition_monitor_timer.sv
`default_nettype none
// ============================================================================
// i3c_bus_timer : saturating time-since-STOP counter with three threshold flags
// Rev 1.0
// ============================================================================
module i3c_bus_timer #(
  parameter int unsigned CntWidth = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                edge_i,
  input  logic                tick_i,
  input  logic [CntWidth-1:0] t_free_i,
  input  logic [CntWidth-1:0] t_aval_i,
  input  logic [CntWidth-1:0] t_idle_i,
  output logic                bus_free_o,
  output logic                bus_available_o,
  output logic                bus_idle_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic                free_q, aval_q, idle_q;

  // START/Sr beats a coincident STOP; a STOP beats the SDA edge that forms it.
  always_comb begin
    armed_d = armed_q;
    cnt_d   = cnt_q;
    if (!enable_i || start_i) begin
      armed_d = 1'b0;
      cnt_d   = '0;
    end else if (stop_i) begin
      armed_d = 1'b1;
      cnt_d   = '0;
    end else if (edge_i) begin
      armed_d = 1'b0;
      cnt_d   = '0;
    end else if (armed_q && tick_i && (cnt_q != {CntWidth{1'b1}})) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
      free_q  <= 1'b0;
      aval_q  <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      free_q  <= armed_d && (cnt_d >= t_free_i);
      aval_q  <= armed_d && (cnt_d >= t_aval_i);
      idle_q  <= armed_d && (cnt_d >= t_idle_i);
    end
  end

  assign bus_free_o      = free_q;
  assign bus_available_o = aval_q;
  assign bus_idle_o      = idle_q;

endmodule
`default_nettype wire

// File: rtl/i3c_bus_condition_monitor.sv
`default_nettype none
// ============================================================================
// i3c_bus_condition_monitor : HDR Exit/Restart, Target Reset and bus-free timing
// Rev 1.0
// ============================================================================
module i3c_bus_condition_monitor
  import i3c_pkg::*;
#(
  parameter int unsigned CntWidth      = 20,
  parameter int unsigned HdrExitFalls  = 4,
  parameter int unsigned HdrRstrtFalls = 2,
  parameter int unsigned TrstFalls     = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  bus_state_t          bus_i,
  input  logic                is_in_hdr_mode_i,
  input  logic [CntWidth-1:0] t_free_i,
  input  logic [CntWidth-1:0] t_aval_i,
  input  logic [CntWidth-1:0] t_idle_i,
  output logic                hdr_exit_detect_o,
  output logic                hdr_restart_detect_o,
  output logic                target_reset_detect_o,
  output logic                bus_free_o,
  output logic                bus_available_o,
  output logic                bus_idle_o
);

  localparam int unsigned FallW = $clog2(max_u(HdrExitFalls, TrstFalls) + 1);
  localparam logic [FallW-1:0] HdrExitCnt  = FallW'(HdrExitFalls);
  localparam logic [FallW-1:0] HdrRstrtCnt = FallW'(HdrRstrtFalls);
  localparam logic [FallW-1:0] TrstCnt     = FallW'(TrstFalls);

  hdr_mon_state_e   hdr_state_q, hdr_state_d;
  trst_state_e      trst_state_q, trst_state_d;
  logic [FallW-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [FallW-1:0] trst_cnt_q, trst_cnt_d;
  logic             hdr_exit_q, hdr_exit_d;
  logic             hdr_rstrt_q, hdr_rstrt_d;
  logic             trst_q, trst_d;

  logic scl_low, sda_fall, any_start, any_edge;

  assign scl_low   = bus_i.scl.stable_low;
  assign sda_fall  = bus_i.sda.neg_edge & scl_low;
  assign any_start = bus_i.start_det | bus_i.rstart_det;
  assign any_edge  = bus_i.scl.pos_edge | bus_i.scl.neg_edge |
                     bus_i.sda.pos_edge | bus_i.sda.neg_edge;

  always_comb begin
    hdr_state_d = hdr_state_q;
    hdr_cnt_d   = hdr_cnt_q;
    hdr_exit_d  = 1'b0;
    hdr_rstrt_d = 1'b0;
    case (hdr_state_q)
      HdrIdle: begin
        if (is_in_hdr_mode_i && scl_low && bus_i.sda.stable_high) begin
          hdr_state_d = HdrArmed;
          hdr_cnt_d   = '0;
        end
      end
      HdrArmed: begin
        if (!is_in_hdr_mode_i) begin
          hdr_state_d = HdrIdle;
        end else if (bus_i.scl.pos_edge) begin
          hdr_rstrt_d = (hdr_cnt_q == HdrRstrtCnt);
          hdr_state_d = HdrIdle;
        end else if (sda_fall) begin
          hdr_cnt_d = hdr_cnt_q + FallW'(1);
          if (hdr_cnt_d == HdrExitCnt) hdr_state_d = HdrWaitStop;
        end
      end
      HdrWaitStop: begin
        if (any_start) begin
          hdr_state_d = HdrIdle;
        end else if (bus_i.stop_det) begin
          hdr_exit_d  = 1'b1;
          hdr_state_d = HdrIdle;
        end
      end
      default: hdr_state_d = HdrIdle;
    endcase
    if (!enable_i) begin
      hdr_state_d = HdrIdle;
      hdr_cnt_d   = '0;
      hdr_exit_d  = 1'b0;
      hdr_rstrt_d = 1'b0;
    end
  end

  // An extra SDA fall after the full count makes the pattern invalid.
  always_comb begin
    trst_state_d = trst_state_q;
    trst_cnt_d   = trst_cnt_q;
    trst_d       = 1'b0;
    case (trst_state_q)
      TrstIdle: begin
        if (sda_fall) begin
          trst_state_d = TrstCount;
          trst_cnt_d   = FallW'(1);
        end
      end
      TrstCount: begin
        if (bus_i.scl.pos_edge) begin
          trst_state_d = TrstIdle;
        end else if (sda_fall) begin
          trst_cnt_d = trst_cnt_q + FallW'(1);
          if (trst_cnt_d == TrstCnt) trst_state_d = TrstWaitSr;
        end
      end
      TrstWaitSr: begin
        if (sda_fall || bus_i.stop_det) begin
          trst_state_d = TrstIdle;
        end else if (bus_i.rstart_det) begin
          trst_state_d = TrstWaitP;
        end
      end
      TrstWaitP: begin
        if (any_start) begin
          trst_state_d = TrstIdle;
        end else if (bus_i.stop_det) begin
          trst_d       = 1'b1;
          trst_state_d = TrstIdle;
        end
      end
      default: trst_state_d = TrstIdle;
    endcase
    if (!enable_i) begin
      trst_state_d = TrstIdle;
      trst_cnt_d   = '0;
      trst_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hdr_state_q  <= HdrIdle;
      trst_state_q <= TrstIdle;
      hdr_cnt_q    <= '0;
      trst_cnt_q   <= '0;
      hdr_exit_q   <= 1'b0;
      hdr_rstrt_q  <= 1'b0;
      trst_q       <= 1'b0;
    end else begin
      hdr_state_q  <= hdr_state_d;
      trst_state_q <= trst_state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      trst_cnt_q   <= trst_cnt_d;
      hdr_exit_q   <= hdr_exit_d;
      hdr_rstrt_q  <= hdr_rstrt_d;
      trst_q       <= trst_d;
    end
  end

  assign hdr_exit_detect_o     = hdr_exit_q;
  assign hdr_restart_detect_o  = hdr_rstrt_q;
  assign target_reset_detect_o = trst_q;

  i3c_bus_timer #(
    .CntWidth(CntWidth)
  ) u_timer (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .start_i        (any_start),
    .stop_i         (bus_i.stop_det),
    .edge_i         (any_edge),
    .tick_i         (bus_i.scl.stable_high & bus_i.sda.stable_high),
    .t_free_i       (t_free_i),
    .t_aval_i       (t_aval_i),
    .t_idle_i       (t_idle_i),
    .bus_free_o     (bus_free_o),
    .bus_available_o(bus_available_o),
    .bus_idle_o     (bus_idle_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_i3c_bus_condition_monitor.sv
`default_nettype none
// ============================================================================
// tb_i3c_bus_condition_monitor : directed bench with a pattern-level reference model
// Rev 1.0
// ============================================================================
module tb_i3c_bus_condition_monitor;
  import i3c_pkg::*;

  localparam int W = 20, W4 = 4, HE = 4, HR = 2, TF = 7;
  localparam line_state_t L_HI = 4'b1000, L_LO = 4'b0100, L_RISE = 4'b0010, L_FALL = 4'b0001;

  logic clk = 1'b0, rst, enable, hdr;
  bus_state_t bus;
  logic [W-1:0]  tf, ta, ti;
  logic [W4-1:0] tf4, ta4, ti4;
  logic exit_o, rstrt_o, trst_o, free_o, aval_o, idle_o;
  logic exit4, rstrt4, trst4, free4, aval4, idle4;

  always #5 clk = ~clk;

  i3c_bus_condition_monitor #(.CntWidth(W)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .bus_i(bus), .is_in_hdr_mode_i(hdr),
    .t_free_i(tf), .t_aval_i(ta), .t_idle_i(ti),
    .hdr_exit_detect_o(exit_o), .hdr_restart_detect_o(rstrt_o), .target_reset_detect_o(trst_o),
    .bus_free_o(free_o), .bus_available_o(aval_o), .bus_idle_o(idle_o));

  i3c_bus_condition_monitor #(.CntWidth(W4)) dut4 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .bus_i(bus), .is_in_hdr_mode_i(hdr),
    .t_free_i(tf4), .t_aval_i(ta4), .t_idle_i(ti4),
    .hdr_exit_detect_o(exit4), .hdr_restart_detect_o(rstrt4), .target_reset_detect_o(trst4),
    .bus_free_o(free4), .bus_available_o(aval4), .bus_idle_o(idle4));

  int vectors = 0, miscompares = 0;
  int n_exit, n_rstrt, n_trst;

  // Reference model: pattern progress as plain counts, timer as "cycles since STOP".
  int     m_hphase, m_hfalls, m_tfalls;
  bit     m_sr_seen;
  longint age;
  bit     e_exit, e_rstrt, e_trst;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_clear();
    m_hphase = 0; m_hfalls = 0; m_tfalls = 0; m_sr_seen = 0; age = -1;
    e_exit = 0; e_rstrt = 0; e_trst = 0;
  endfunction

  function automatic void model_step();
    bit low  = bus.scl.stable_low;
    bit fall = bus.sda.neg_edge && low;
    bit brk  = bus.start_det || bus.rstart_det;
    bit edg  = bus.scl.pos_edge | bus.scl.neg_edge | bus.sda.pos_edge | bus.sda.neg_edge;
    e_exit = 0; e_rstrt = 0; e_trst = 0;
    if (!enable) begin model_clear(); return; end
    // HDR: phase 0 idle, 1 collecting falls, 2 full pattern awaiting STOP
    if (m_hphase == 0) begin
      if (hdr && low && bus.sda.stable_high) begin m_hphase = 1; m_hfalls = 0; end
    end else if (m_hphase == 1) begin
      if (!hdr) m_hphase = 0;
      else if (bus.scl.pos_edge) begin e_rstrt = (m_hfalls == HR); m_hphase = 0; end
      else if (fall) begin m_hfalls++; if (m_hfalls == HE) m_hphase = 2; end
    end else begin
      if (brk) m_hphase = 0;
      else if (bus.stop_det) begin e_exit = 1; m_hphase = 0; end
    end
    // Target reset: count falls, then need Sr, then P
    if (m_tfalls == 0) begin
      if (fall) begin m_tfalls = 1; m_sr_seen = 0; end
    end else if (m_tfalls < TF) begin
      if (bus.scl.pos_edge) m_tfalls = 0;
      else if (fall) m_tfalls++;
    end else if (!m_sr_seen) begin
      if (fall || bus.stop_det) m_tfalls = 0;
      else if (bus.rstart_det) m_sr_seen = 1;
    end else begin
      if (brk) m_tfalls = 0;
      else if (bus.stop_det) begin e_trst = 1; m_tfalls = 0; end
    end
    if (brk) age = -1;
    else if (bus.stop_det) age = 0;
    else if (edg) age = -1;
    else if (age >= 0 && bus.scl.stable_high && bus.sda.stable_high) age++;
  endfunction

  function automatic longint sat(input longint a, input int w);
    longint mx = (64'd1 << w) - 1;
    return (a > mx) ? mx : a;
  endfunction

  task automatic tick();
    longint a20, a4;
    @(posedge clk);
    model_step();
    @(negedge clk);
    a20 = sat(age, W); a4 = sat(age, W4);
    chk("hdr_exit", exit_o, e_exit);
    chk("hdr_restart", rstrt_o, e_rstrt);
    chk("target_reset", trst_o, e_trst);
    chk("bus_free", free_o, (age >= 0) && (a20 >= longint'(tf)));
    chk("bus_available", aval_o, (age >= 0) && (a20 >= longint'(ta)));
    chk("bus_idle", idle_o, (age >= 0) && (a20 >= longint'(ti)));
    chk("w4_pulses", {exit4, rstrt4, trst4}, {e_exit, e_rstrt, e_trst});
    chk("w4_bus_free", free4, (age >= 0) && (a4 >= longint'(tf4)));
    chk("w4_bus_available", aval4, (age >= 0) && (a4 >= longint'(ta4)));
    chk("w4_bus_idle", idle4, (age >= 0) && (a4 >= longint'(ti4)));
    n_exit += int'(exit_o); n_rstrt += int'(rstrt_o); n_trst += int'(trst_o);
  endtask

  task automatic vec(input line_state_t s, input line_state_t d,
                     input logic st = 0, input logic rs = 0, input logic sp = 0);
    bus = '{scl: s, sda: d, start_det: st, rstart_det: rs, stop_det: sp};
    tick();
  endtask

  task automatic fall_seq(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) vec(L_LO, L_RISE);
      vec(L_LO, L_FALL);
      vec(L_LO, L_LO);
    end
  endtask

  task automatic sr_seq();
    vec(L_LO, L_RISE); vec(L_RISE, L_HI); vec(L_HI, L_FALL, 0, 1, 0);
    vec(L_FALL, L_LO); vec(L_LO, L_LO);
  endtask

  task automatic stop_seq();
    vec(L_RISE, L_LO); vec(L_HI, L_LO); vec(L_HI, L_RISE, 0, 0, 1);
  endtask

  task automatic arm();
    vec(L_FALL, L_HI); vec(L_LO, L_HI);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_clear();
    chk("reset_outputs", {exit_o, rstrt_o, trst_o, free_o, aval_o, idle_o}, 0);
    rst = 1'b0;
    n_exit = 0; n_rstrt = 0; n_trst = 0;
    bus = '{scl: L_HI, sda: L_HI, start_det: 0, rstart_det: 0, stop_det: 0};
  endtask

  initial begin
    int first_free, first_aval, first_idle, cnt_idle4, cnt_aval4;
    rst = 1'b1; enable = 1'b1; hdr = 1'b0;
    tf = 20'd10; ta = 20'd20; ti = 20'd30;
    tf4 = 4'd3; ta4 = 4'd0; ti4 = 4'd15;
    bus = '{scl: L_HI, sda: L_HI, start_det: 0, rstart_det: 0, stop_det: 0};
    model_clear();
    @(negedge clk);
    do_reset();

    // 1: HDR Exit
    hdr = 1'b1; arm(); fall_seq(4); stop_seq();
    chk("t1_exit_after_stop", exit_o, 1);
    vec(L_HI, L_HI);
    chk("t1_exit_count", n_exit, 1);
    chk("t1_restart_count", n_rstrt, 0);

    // 2: HDR Restart with 2 falls, then 3 falls gives nothing
    do_reset(); hdr = 1'b1; arm(); fall_seq(2); vec(L_RISE, L_LO);
    chk("t2_restart_pulse", rstrt_o, 1);
    vec(L_HI, L_LO); vec(L_FALL, L_LO); vec(L_LO, L_RISE); vec(L_LO, L_HI);
    fall_seq(3); vec(L_RISE, L_LO); vec(L_HI, L_LO);
    chk("t2_restart_count", n_rstrt, 1);
    chk("t2_exit_count", n_exit, 0);
    hdr = 1'b0;

    // 3: Target Reset with 7, 6 and 8 falls
    do_reset(); arm(); fall_seq(7); sr_seq(); stop_seq();
    chk("t3_trst_after_stop", trst_o, 1);
    vec(L_HI, L_HI); arm(); fall_seq(6); sr_seq(); stop_seq();
    vec(L_HI, L_HI); arm(); fall_seq(8); sr_seq(); stop_seq();
    vec(L_HI, L_HI);
    chk("t3_trst_count", n_trst, 1);

    // 4: bus timers after STOP, thresholds 10/20/30
    do_reset(); first_free = 0; first_aval = 0; first_idle = 0;
    for (int c = 1; c <= 35; c++) begin
      vec(L_HI, L_HI, 0, 0, (c == 1));
      if (free_o && first_free == 0) first_free = c;
      if (aval_o && first_aval == 0) first_aval = c;
      if (idle_o && first_idle == 0) first_idle = c;
    end
    chk("t4_first_free", first_free, 11);
    chk("t4_first_aval", first_aval, 21);
    chk("t4_first_idle", first_idle, 31);
    for (int c = 1; c <= 25; c++) begin
      if (c == 25) vec(L_HI, L_FALL);
      else vec(L_HI, L_HI, 0, 0, (c == 1));
      if (c == 24) chk("t4_levels_c24", {free_o, aval_o, idle_o}, 3'b110);
    end
    chk("t4_levels_after_fall", {free_o, aval_o, idle_o}, 3'b000);

    // 5: 4-bit timer saturates and holds idle
    do_reset(); cnt_idle4 = 0; cnt_aval4 = 0;
    for (int c = 1; c <= 41; c++) begin
      vec(L_HI, L_HI, 0, 0, (c == 1));
      cnt_idle4 += int'(idle4);
      cnt_aval4 += int'(aval4);
    end
    chk("t5_idle4_cycles", cnt_idle4, 26);
    chk("t5_aval4_cycles", cnt_aval4, 41);
    vec(L_HI, L_HI, 1, 0, 1);
    chk("t5_start_beats_stop", aval4, 0);

    // 6: reset mid-TRST, enable low mid-HDR
    do_reset(); arm(); fall_seq(5);
    do_reset(); bus = '{scl: L_LO, sda: L_LO, start_det: 0, rstart_det: 0, stop_det: 0};
    vec(L_LO, L_RISE); fall_seq(2); sr_seq(); stop_seq(); vec(L_HI, L_HI);
    chk("t6_trst_after_reset", n_trst, 0);
    hdr = 1'b1; arm(); fall_seq(2);
    enable = 1'b0; vec(L_LO, L_LO); enable = 1'b1;
    vec(L_LO, L_RISE); fall_seq(2); stop_seq(); vec(L_HI, L_HI);
    chk("t6_exit_after_disable", n_exit, 0);

    // HDR Exit and Target Reset completing on the same STOP
    do_reset(); hdr = 1'b0; arm(); fall_seq(7); sr_seq();
    hdr = 1'b1; vec(L_LO, L_RISE); vec(L_LO, L_HI); fall_seq(4); stop_seq();
    chk("both_pulses", {exit_o, trst_o}, 2'b11);
    vec(L_HI, L_HI);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
